// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter.
// Owner enum, access-size encodings and the memory request bundle.
package dmem_pkg;

  localparam int unsigned DMEM_DW = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  typedef struct packed {
    logic               we;
    logic [DMEM_DW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic [1:0]         mtype;
    logic               sign;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_stats.sv
// dmem_arb_stats: free-running stall / ext-transfer counters (wrap mod 2^32).
// In: stall_i, xfer_i per-cycle events; out: stat_core_stall_o, stat_ext_xfer_o.
module dmem_arb_stats
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        xfer_i,
  output logic [31:0] stat_core_stall_o,
  output logic [31:0] stat_ext_xfer_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] xfer_q, xfer_d;

  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (stall_i) stall_d = stall_q + 32'd1;
    if (xfer_i)  xfer_d  = xfer_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stat_core_stall_o = stall_q;
  assign stat_ext_xfer_o   = xfer_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the MEM stage (priority)
// and an ext valid/ready port; core_*, ext_*, mem_* buses; DMEM_ARB_STATS_EN adds stat_*.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DMEM_DW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [DATA_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic [1:0]            core_type_i,
  input  logic                  core_sign_i,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  ext_valid_i,
  output logic                  ext_ready_o,
  input  logic                  ext_we_i,
  input  logic [DATA_WIDTH-1:0] ext_addr_i,
  input  logic [DATA_WIDTH-1:0] ext_wdata_i,
  input  logic [1:0]            ext_type_i,
  input  logic                  ext_sign_i,
  output logic                  ext_rvalid_o,
  output logic [DATA_WIDTH-1:0] ext_rdata_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]           stat_core_stall_o,
  output logic [31:0]           stat_ext_xfer_o,
`endif
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [1:0]            mem_type_o,
  output logic                  mem_sign_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  owner_t                owner_q, owner_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
  mem_req_t              core_r, ext_r, port_r;
  logic                  grant_ext;

  assign core_r = '{we: core_we_i, addr: core_addr_i,
                    wdata: core_wdata_i, mtype: core_type_i,
                    sign: core_sign_i};
  assign ext_r  = '{we: ext_we_i, addr: ext_addr_i,
                    wdata: ext_wdata_i, mtype: ext_type_i,
                    sign: ext_sign_i};

  // rst_ni gating keeps every handshake quiet while held in reset
  assign grant_ext = rst_ni && ext_valid_i &&
                     (!core_req_i || starve_q == LIMIT);

  // idle cycles leave the core bus on the port
  assign port_r = grant_ext ? ext_r : core_r;

  assign mem_we_o    = rst_ni &&
                       (grant_ext ? ext_r.we : (core_req_i && core_r.we));
  assign mem_addr_o  = port_r.addr;
  assign mem_wdata_o = port_r.wdata;
  assign mem_type_o  = port_r.mtype;
  assign mem_sign_o  = port_r.sign;

  assign core_rdata_o = mem_rdata_i;
  assign core_stall_o = core_req_i && grant_ext;
  assign ext_ready_o  = grant_ext;
  assign ext_rvalid_o = (owner_q == OWN_EXT);
  assign ext_rdata_o  = ext_rdata_q;

  always_comb begin
    owner_d     = OWN_NONE;
    starve_d    = starve_q;
    ext_rdata_d = ext_rdata_q;
    unique case (1'b1)
      grant_ext:               owner_d = OWN_EXT;
      !grant_ext & core_req_i: owner_d = OWN_CORE;
      default:                 owner_d = OWN_NONE;
    endcase
    if (!ext_valid_i || grant_ext) begin
      starve_d = '0;
    end else if (core_req_i && starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
    if (grant_ext && !ext_we_i) ext_rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      ext_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk               (clk),
    .rst_ni            (rst_ni),
    .stall_i           (core_stall_o),
    .xfer_i            (grant_ext),
    .stat_core_stall_o (stat_core_stall_o),
    .stat_ext_xfer_o   (stat_ext_xfer_o)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized checks of dmem_arbiter
// against a cycle-level reference model and a byte-addressed memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i, core_sign_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic [1:0]  core_type_i;
  logic        core_stall_o;
  logic        ext_valid_i, ext_ready_o, ext_we_i, ext_sign_i;
  logic [31:0] ext_addr_i, ext_wdata_i, ext_rdata_o;
  logic [1:0]  ext_type_i;
  logic        ext_rvalid_o;
  logic        mem_we_o, mem_sign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  mem_type_o;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_stall_o, stat_ext_xfer_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int          losses;
  logic        prev_grant;
  logic [31:0] exp_rdata;
  logic [31:0] model_mem [0:255];

  logic [7:0]  env_mem [0:1023];
  logic        env_init = 1'b0;
  logic [9:0]  ea;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(STARVE)) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_type_i  (core_type_i),
    .core_sign_i  (core_sign_i),
    .core_rdata_o (core_rdata_o),
    .core_stall_o (core_stall_o),
    .ext_valid_i  (ext_valid_i),
    .ext_ready_o  (ext_ready_o),
    .ext_we_i     (ext_we_i),
    .ext_addr_i   (ext_addr_i),
    .ext_wdata_i  (ext_wdata_i),
    .ext_type_i   (ext_type_i),
    .ext_sign_i   (ext_sign_i),
    .ext_rvalid_o (ext_rvalid_o),
    .ext_rdata_o  (ext_rdata_o),
`ifdef DMEM_ARB_STATS_EN
    .stat_core_stall_o (stat_core_stall_o),
    .stat_ext_xfer_o   (stat_ext_xfer_o),
`endif
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_type_o   (mem_type_o),
    .mem_sign_o   (mem_sign_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  function automatic logic [31:0] pat(int w);
    return 32'hA500_0000 | 32'(w);
  endfunction

  // byte-addressed memory: combinational read, write on the edge
  always_comb begin
    ea = {mem_addr_o[9:2], 2'b00};
    mem_rdata_i = {env_mem[ea | 10'd3], env_mem[ea | 10'd2],
                   env_mem[ea | 10'd1], env_mem[ea]};
  end

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 1024; i++)
        env_mem[i] <= 8'(pat(i / 4) >> (8 * (i % 4)));
      env_init <= 1'b1;
    end else if (mem_we_o) begin
      case (mem_type_o)
        MT_BYTE: env_mem[mem_addr_o[9:0]] <= mem_wdata_o[7:0];
        MT_HALF: begin
          env_mem[{mem_addr_o[9:1], 1'b0}] <= mem_wdata_o[7:0];
          env_mem[{mem_addr_o[9:1], 1'b1}] <= mem_wdata_o[15:8];
        end
        default: begin
          env_mem[{mem_addr_o[9:2], 2'd0}] <= mem_wdata_o[7:0];
          env_mem[{mem_addr_o[9:2], 2'd1}] <= mem_wdata_o[15:8];
          env_mem[{mem_addr_o[9:2], 2'd2}] <= mem_wdata_o[23:16];
          env_mem[{mem_addr_o[9:2], 2'd3}] <= mem_wdata_o[31:24];
        end
      endcase
    end
  end

  function automatic mem_req_t mk(logic we, logic [31:0] a,
                                  logic [31:0] d, logic [1:0] t);
    mem_req_t r;
    r = '{we: we, addr: a, wdata: d, mtype: t, sign: 1'b0};
    return r;
  endfunction

  function automatic mem_req_t rnd();
    mem_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 1023));
    r.wdata = $urandom;
    r.mtype = 2'($urandom_range(0, 2));
    r.sign  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // word-granular model memory, lanes picked from the access size
  function automatic void model_store(mem_req_t r);
    int w;
    w = int'(r.addr[9:2]);
    case (r.mtype)
      MT_BYTE: model_mem[w][8 * r.addr[1:0] +: 8] = r.wdata[7:0];
      MT_HALF: model_mem[w][16 * r.addr[1] +: 16] = r.wdata[15:0];
      default: model_mem[w] = r.wdata;
    endcase
  endfunction

  function automatic void model_reset();
    losses     = 0;
    prev_grant = 1'b0;
    exp_rdata  = '0;
  endfunction

  // one bus cycle: drive after negedge, check, advance the model
  task automatic step(input logic creq, input mem_req_t c,
                      input logic ev, input mem_req_t e,
                      output logic g);
    logic       ge;
    mem_req_t   own;
    logic       we_x;
    logic [3:0] ctl_x;
    logic [31:0] rd_x;
    @(negedge clk);
    core_req_i = creq; core_we_i = c.we; core_addr_i = c.addr;
    core_wdata_i = c.wdata; core_type_i = c.mtype; core_sign_i = c.sign;
    ext_valid_i = ev; ext_we_i = e.we; ext_addr_i = e.addr;
    ext_wdata_i = e.wdata; ext_type_i = e.mtype; ext_sign_i = e.sign;
    #1;
    ge    = ev && (!creq || losses >= STARVE);
    own   = ge ? e : c;
    we_x  = ge ? e.we : (creq && c.we);
    ctl_x = {ge, creq && ge, we_x, prev_grant};
    rd_x  = model_mem[own.addr[9:2]];
    n_tests++;
    if ({ext_ready_o, core_stall_o, mem_we_o, ext_rvalid_o} !== ctl_x) begin
      n_fail++;
      $display("FAIL ctrl rdy/stall/we/rvalid: got %b expected %b",
        {ext_ready_o, core_stall_o, mem_we_o, ext_rvalid_o}, ctl_x);
    end
    n_tests++;
    if ({mem_addr_o, mem_wdata_o, mem_type_o, mem_sign_o} !==
        {own.addr, own.wdata, own.mtype, own.sign}) begin
      n_fail++;
      $display("FAIL port mux: got %h/%h/%b/%b expected %h/%h/%b/%b",
        mem_addr_o, mem_wdata_o, mem_type_o, mem_sign_o,
        own.addr, own.wdata, own.mtype, own.sign);
    end
    n_tests++;
    if (ext_rdata_o !== exp_rdata) begin
      n_fail++;
      $display("FAIL ext_rdata: got %h expected %h", ext_rdata_o, exp_rdata);
    end
    n_tests++;
    if (core_rdata_o !== rd_x) begin
      n_fail++;
      $display("FAIL core_rdata: got %h expected %h", core_rdata_o, rd_x);
    end
    if (ge && !e.we) exp_rdata = rd_x;
    if (we_x) model_store(own);
    prev_grant = ge;
    if (!ev || ge) losses = 0;
    else if (creq) losses++;
    g = ge;
  endtask

  mem_req_t idle;
  logic     g;

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    step(1'b0, idle, 1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    core_req_i = 1'b1;
    core_we_i  = 1'b1;
    #1;
    n_tests++;
    if ({ext_ready_o, core_stall_o, mem_we_o, ext_rvalid_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b expected 0000",
        {ext_ready_o, core_stall_o, mem_we_o, ext_rvalid_o});
    end
    n_tests++;
    if (ext_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset rdata: got %h expected 0", ext_rdata_o);
    end
    n_tests++;
    if (dut.owner_q !== OWN_NONE) begin
      n_fail++;
      $display("FAIL reset owner: got %0d expected 0", dut.owner_q);
    end
    @(negedge clk);
    core_req_i = 1'b0; core_we_i = 1'b0; ext_valid_i = 1'b0;
    rst_ni = 1'b1;
    model_reset();
    step(1'b0, idle, 1'b0, idle, g);
    step(1'b0, idle, 1'b0, idle, g);
    n_tests++;
    if (mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle we: got %b expected 0", mem_we_o);
    end
  endtask

  task automatic test_ext_only();
    step(1'b0, idle, 1'b1, mk(1'b1, 32'h40, 32'hDEADBEEF, MT_WORD), g);
    n_tests++;
    if (ext_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ext wr ready: got %b expected 1", ext_ready_o);
    end
    step(1'b0, idle, 1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    n_tests++;
    if (ext_rvalid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ext wr rvalid: got %b expected 1", ext_rvalid_o);
    end
    step(1'b0, idle, 1'b0, idle, g);
    n_tests++;
    if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL ext rd data: got %b/%h expected 1/deadbeef",
        ext_rvalid_o, ext_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, mk(1'b0, 32'h80, 32'h0, MT_WORD),
         1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    n_tests++;
    if ({core_stall_o, ext_ready_o, mem_addr_o} !== {2'b00, 32'h80}) begin
      n_fail++;
      $display("FAIL simul core wins: got %b%b/%h expected 00/80",
        core_stall_o, ext_ready_o, mem_addr_o);
    end
    step(1'b0, idle, 1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    n_tests++;
    if ({dut.starve_q, ext_ready_o} !== {3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL simul starve/ready: got %0d/%b expected 1/1",
        dut.starve_q, ext_ready_o);
    end
    step(1'b0, idle, 1'b0, idle, g);
  endtask

  task automatic test_starvation();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, mk(1'b1, 32'h80, $urandom, MT_WORD),
           1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
      n_tests++;
      if ({core_stall_o, ext_ready_o} !== {2{k % 5 == 0}}) begin
        n_fail++;
        $display("FAIL starve cycle %0d: got %b%b expected %b%b", k,
          core_stall_o, ext_ready_o, k % 5 == 0, k % 5 == 0);
      end
    end
    step(1'b0, idle, 1'b0, idle, g);
  endtask

  task automatic test_byte_store();
    step(1'b1, mk(1'b1, 32'h43, 32'h000000AA, MT_BYTE),
         1'b1, mk(1'b1, 32'h48, 32'h11223344, MT_WORD), g);
    n_tests++;
    if ({mem_we_o, core_stall_o, mem_addr_o} !== {2'b10, 32'h43}) begin
      n_fail++;
      $display("FAIL byte store core: got %b%b/%h expected 10/43",
        mem_we_o, core_stall_o, mem_addr_o);
    end
    step(1'b0, idle, 1'b1, mk(1'b1, 32'h48, 32'h11223344, MT_WORD), g);
    n_tests++;
    if ({mem_we_o, mem_addr_o} !== {1'b1, 32'h48}) begin
      n_fail++;
      $display("FAIL byte store ext: got %b/%h expected 1/48",
        mem_we_o, mem_addr_o);
    end
    step(1'b0, idle, 1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    step(1'b0, idle, 1'b0, idle, g);
    n_tests++;
    if (ext_rdata_o !== 32'hAAADBEEF) begin
      n_fail++;
      $display("FAIL byte lane: got %h expected aaadbeef", ext_rdata_o);
    end
  endtask

  task automatic test_random();
    mem_req_t c, e;
    logic     creq, ev, gr, hold_c, hold_e;
    c = idle; e = idle; creq = 1'b0; ev = 1'b0;
    hold_c = 1'b0; hold_e = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!hold_c) begin
        creq = ($urandom_range(0, 3) != 0);
        c    = rnd();
      end
      if (!hold_e) begin
        ev = ($urandom_range(0, 1) == 1);
        e  = rnd();
      end
      step(creq, c, ev, e, gr);
      hold_c = creq && gr;
      hold_e = ev && !gr;
    end
    step(1'b0, idle, 1'b0, idle, gr);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++)
      step(1'b1, mk(1'b0, 32'h80, 32'h0, MT_WORD),
           1'b1, mk(1'b0, 32'h40, 32'h0, MT_WORD), g);
    @(negedge clk);
    n_tests++;
    if ({stat_core_stall_o, stat_ext_xfer_o} !== {32'd4, 32'd4}) begin
      n_fail++;
      $display("FAIL stats: got %0d/%0d expected 4/4",
        stat_core_stall_o, stat_ext_xfer_o);
    end
    step(1'b0, idle, 1'b0, idle, g);
  endtask
`endif

  initial begin
    idle = mk(1'b0, 32'h0, 32'h0, MT_WORD);
    for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
    model_reset();
    rst_ni = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0;
    core_wdata_i = '0; core_type_i = MT_WORD; core_sign_i = 1'b0;
    ext_valid_i = 1'b0; ext_we_i = 1'b0; ext_addr_i = '0;
    ext_wdata_i = '0; ext_type_i = MT_WORD; ext_sign_i = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_ext_only();
    test_simultaneous();
    test_starvation();
    test_byte_store();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
